// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default frame constants used by RX and TX.
package uart_pkg;

    localparam int DBIT_DEF       = 8;
    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a previous-value flop for falling-edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Flops reset high so an idle line never looks like a start edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= rx;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rx_s = sync_reg;
    assign fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled mid-bit sampling of 8N1 frames, LSB first, with frame error flag.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop plus a parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int SB_TICK    = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            baud_rate,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int TW = $clog2((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_TICK = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] AFTER_DATA = ST_STOP;
`endif

    logic            rx_s;
    logic            fall;

    logic [2:0]      state_reg, state_next;
    logic [TW-1:0]   tick_reg, tick_next;
    logic [BW-1:0]   bit_reg, bit_next;
    logic [DBIT-1:0] shift_reg, shift_next;
    logic [DBIT-1:0] d_out_reg, d_out_next;
    logic            done_reg, done_next;
    logic            ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_reg, par_bit_next;
    logic            perr_reg, perr_next;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        d_out_next = d_out_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit_reg;
        perr_next    = perr_reg;
`endif
        case (state_reg)
            // Only a genuine high-to-low edge starts a frame, so a stuck-low line cannot retrigger.
            ST_IDLE: begin
                if (fall) begin
                    tick_next  = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_rate) begin
                    if (tick_reg == MID_TICK) begin
                        if (!rx_s) begin
                            tick_next  = '0;
                            bit_next   = '0;
                            state_next = ST_DATA;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_rate) begin
                    if (tick_reg == LAST_TICK) begin
                        shift_next = {rx_s, shift_reg[DBIT-1:1]};
                        tick_next  = '0;
                        if (bit_reg == LAST_BIT) begin
                            state_next = AFTER_DATA;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_rate) begin
                    if (tick_reg == LAST_TICK) begin
                        par_bit_next = rx_s;
                        tick_next    = '0;
                        state_next   = ST_STOP;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
`endif
            // Sampling mid-stop-bit and returning to IDLE here lets a back-to-back start edge be caught.
            ST_STOP: begin
                if (baud_rate) begin
                    if (tick_reg == STOP_TICK) begin
                        d_out_next = shift_reg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = ((^shift_reg) ^ par_bit_reg) != PARITY_ODD;
`endif
                        state_next = ST_IDLE;
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            d_out_reg <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= 1'b0;
            perr_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            d_out_reg <= d_out_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= par_bit_next;
            perr_reg    <= perr_next;
`endif
        end
    end

    assign d_out     = d_out_reg;
    assign rx_done   = done_reg;
    assign frame_err = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_reg;
`endif

endmodule
